// File: rtl/wishbone_nn_stream_fifo_if.sv
// +----------------------------------------------------------------------------+
// | wishbone_nn_stream_fifo_if : Wishbone slave + in/out stream bundle           |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface wishbone_nn_stream_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wbs_stb_i;
  logic                  wbs_cyc_i;
  logic                  wbs_we_i;
  logic [3:0]            wbs_sel_i;
  logic [31:0]           wbs_adr_i;
  logic [31:0]           wbs_dat_i;
  logic                  wbs_ack_o;
  logic [31:0]           wbs_dat_o;
  logic                  m_valid_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_ready_i;
  logic                  s_valid_i;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_ready_o;

  // Block-side view: Wishbone slave, stream master towards the core, stream slave from it.
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output m_valid_o, m_data_o,
    input  m_ready_i,
    input  s_valid_i, s_data_i,
    output s_ready_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  m_valid_o, m_data_o,
    output m_ready_i,
    output s_valid_i, s_data_i,
    input  s_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/wishbone_nn_stream_fifo.sv
// +----------------------------------------------------------------------------+
// | wishbone_nn_stream_fifo : Wishbone register window over two stream FIFOs    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wishbone_nn_stream_fifo #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH        = 16
) (
  input  wire logic                 wb_clk_i,
  input  wire logic                 wb_rst_ni,
  wishbone_nn_stream_fifo_if.slave  bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] REG_DATA_IN  = 2'd0;
  localparam logic [1:0] REG_DATA_OUT = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  logic [DATA_WIDTH-1:0] in_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_q [DEPTH];

  logic [AW-1:0] in_wr_ptr_q,  in_wr_ptr_d,  in_rd_ptr_q,  in_rd_ptr_d;
  logic [AW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [CW-1:0] in_count_q,   in_count_d,   out_count_q,  out_count_d;
  logic          in_ovf_q,     in_ovf_d,     out_unf_q,    out_unf_d;
  logic          ack_q,        ack_d;
  logic [31:0]   dat_q,        dat_d;

  logic          hit, req, wr_req, rd_req;
  logic [1:0]    reg_sel;
  logic          in_empty, in_full, out_empty, out_full;
  logic          wr_data_in, in_push, in_pop, ovf_evt;
  logic          rd_data_out, out_push, out_pop, unf_evt;
  logic          ctrl_wr, flush_in, flush_out, clr_err;
  logic [31:0]   status, rd_data;
  logic          unused_bits;

  // A request is accepted only while no ack is outstanding, so each access acks exactly once.
  assign hit     = bus.wbs_adr_i[31:4] == BASE_ADDRESS[31:4];
  assign req     = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack_q & hit;
  assign wr_req  = req & bus.wbs_we_i;
  assign rd_req  = req & ~bus.wbs_we_i;
  assign reg_sel = bus.wbs_adr_i[3:2];

  assign in_empty  = in_count_q == '0;
  assign in_full   = in_count_q == FULL_CNT;
  assign out_empty = out_count_q == '0;
  assign out_full  = out_count_q == FULL_CNT;

  assign wr_data_in  = wr_req & (reg_sel == REG_DATA_IN);
  assign in_push     = wr_data_in & ~in_full;
  assign ovf_evt     = wr_data_in & in_full;
  assign in_pop      = ~in_empty & bus.m_ready_i;

  assign rd_data_out = rd_req & (reg_sel == REG_DATA_OUT);
  assign out_pop     = rd_data_out & ~out_empty;
  assign unf_evt     = rd_data_out & out_empty;
  assign out_push    = bus.s_valid_i & bus.s_ready_o;

  assign ctrl_wr   = wr_req & (reg_sel == REG_CTRL);
  assign flush_in  = ctrl_wr & bus.wbs_dat_i[0];
  assign flush_out = ctrl_wr & bus.wbs_dat_i[1];
  assign clr_err   = ctrl_wr & bus.wbs_dat_i[2];

  assign status = {8'h00, 8'(out_count_q), 8'(in_count_q), 2'b00,
                   out_unf_q, in_ovf_q, out_full, out_empty, in_full, in_empty};

  assign bus.m_valid_o = ~in_empty;
  assign bus.m_data_o  = in_empty ? '0 : in_mem_q[in_rd_ptr_q];
  assign bus.s_ready_o = wb_rst_ni & ~out_full;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;

  assign unused_bits = ^{bus.wbs_sel_i, bus.wbs_adr_i[1:0], bus.wbs_dat_i};

  always_comb begin
    in_wr_ptr_d  = in_wr_ptr_q;
    in_rd_ptr_d  = in_rd_ptr_q;
    in_count_d   = in_count_q;
    out_wr_ptr_d = out_wr_ptr_q;
    out_rd_ptr_d = out_rd_ptr_q;
    out_count_d  = out_count_q;

    if (in_push) in_wr_ptr_d = in_wr_ptr_q + AW'(1);
    if (in_pop)  in_rd_ptr_d = in_rd_ptr_q + AW'(1);
    case ({in_push, in_pop})
      2'b10:   in_count_d = in_count_q + CW'(1);
      2'b01:   in_count_d = in_count_q - CW'(1);
      default: in_count_d = in_count_q;
    endcase

    if (out_push) out_wr_ptr_d = out_wr_ptr_q + AW'(1);
    if (out_pop)  out_rd_ptr_d = out_rd_ptr_q + AW'(1);
    case ({out_push, out_pop})
      2'b10:   out_count_d = out_count_q + CW'(1);
      2'b01:   out_count_d = out_count_q - CW'(1);
      default: out_count_d = out_count_q;
    endcase

    // Flush wins over any push or pop landing on the same edge.
    if (flush_in) begin
      in_wr_ptr_d = '0;
      in_rd_ptr_d = '0;
      in_count_d  = '0;
    end
    if (flush_out) begin
      out_wr_ptr_d = '0;
      out_rd_ptr_d = '0;
      out_count_d  = '0;
    end

    in_ovf_d  = (in_ovf_q  & ~clr_err) | ovf_evt;
    out_unf_d = (out_unf_q & ~clr_err) | unf_evt;

    rd_data = '0;
    case (reg_sel)
      REG_DATA_OUT: if (!out_empty) rd_data = 32'(out_mem_q[out_rd_ptr_q]);
      REG_STATUS:   rd_data = status;
      default:      rd_data = '0;
    endcase

    ack_d = req;
    dat_d = rd_req ? rd_data : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      in_count_q   <= '0;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_count_q  <= '0;
      in_ovf_q     <= 1'b0;
      out_unf_q    <= 1'b0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_count_q   <= in_count_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_count_q  <= out_count_d;
      in_ovf_q     <= in_ovf_d;
      out_unf_q    <= out_unf_d;
      ack_q        <= ack_d;
      dat_q        <= dat_d;
    end
  end

  // Storage is deliberately left out of reset; only pointers and counts define validity.
  always_ff @(posedge wb_clk_i) begin
    if (in_push)  in_mem_q[in_wr_ptr_q]   <= bus.wbs_dat_i[DATA_WIDTH-1:0];
    if (out_push) out_mem_q[out_wr_ptr_q] <= bus.s_data_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_wishbone_nn_stream_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_wishbone_nn_stream_fifo : queue-model bench for wishbone_nn_stream_fifo  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wishbone_nn_stream_fifo;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  wishbone_nn_stream_fifo_if #(.DATA_WIDTH(DW)) bus ();

  wishbone_nn_stream_fifo #(
    .BASE_ADDRESS (BASE),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  initial forever #5 clk = ~clk;

  // Reference model: two queues, two sticky flags, and the expected bus response.
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  logic        e_ack = 1'b0;
  logic [31:0] e_dat = 32'h0;

  function automatic logic [31:0] stat(int ni, int no, bit ov, bit un);
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (ni == 0);
    s[1]     = (ni == DEPTH);
    s[2]     = (no == 0);
    s[3]     = (no == DEPTH);
    s[4]     = ov;
    s[5]     = un;
    s[15:8]  = ni[7:0];
    s[23:16] = no[7:0];
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int          ni, no;
    bit          req, set_ovf, set_unf, clr, fl_in, fl_out;
    logic [31:0] rd;
    if (!rst_n) begin
      in_q.delete();
      out_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      e_ack = 1'b0;
      e_dat = 32'h0;
    end else begin
      ni = in_q.size();
      no = out_q.size();
      req = bus.wbs_stb_i && bus.wbs_cyc_i && !e_ack && (bus.wbs_adr_i[31:4] == BASE[31:4]);
      rd = 32'h0; set_ovf = 0; set_unf = 0; clr = 0; fl_in = 0; fl_out = 0;
      if (ni > 0 && bus.m_ready_i) void'(in_q.pop_front());
      if (req) begin
        case (bus.wbs_adr_i[3:2])
          2'd0: if (bus.wbs_we_i) begin
                  if (ni == DEPTH) set_ovf = 1;
                  else in_q.push_back(bus.wbs_dat_i);
                end
          2'd1: if (!bus.wbs_we_i) begin
                  if (no == 0) set_unf = 1;
                  else rd = out_q.pop_front();
                end
          2'd2: if (!bus.wbs_we_i) rd = stat(ni, no, m_ovf, m_unf);
          default: if (bus.wbs_we_i) begin
                  fl_in  = bus.wbs_dat_i[0];
                  fl_out = bus.wbs_dat_i[1];
                  clr    = bus.wbs_dat_i[2];
                end
        endcase
      end
      if (bus.s_valid_i && no < DEPTH) out_q.push_back(bus.s_data_i);
      if (fl_in)  in_q.delete();
      if (fl_out) out_q.delete();
      m_ovf = (m_ovf && !clr) || set_ovf;
      m_unf = (m_unf && !clr) || set_unf;
      e_ack = req;
      e_dat = (req && !bus.wbs_we_i) ? rd : 32'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("ack",     32'(bus.wbs_ack_o), 32'(e_ack));
      check("dat_o",   bus.wbs_dat_o,      e_dat);
      check("m_valid", 32'(bus.m_valid_o), 32'(in_q.size() > 0));
      check("m_data",  bus.m_data_o,       (in_q.size() > 0) ? in_q[0] : 32'h0);
      check("s_ready", 32'(bus.s_ready_o), 32'(rst_n && out_q.size() < DEPTH));
    end
  endtask

  // Starts at posedge+1 and returns at posedge+1 once the single ack cycle has passed.
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         output logic [31:0] rdat, output bit acked);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wd;
    acked = 1'b0;
    rdat  = 32'h0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdat  = bus.wbs_dat_o;
      end
    end
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] r;
    bit          a;
    wb_xfer(1'b1, adr, d, r, a);
    check("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    bit a;
    wb_xfer(1'b0, adr, 32'h0, d, a);
    check("rd_ack", 32'(a), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    bit          a, take, busy;
    int          n, age, r;

    bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.m_ready_i = 0; bus.s_valid_i = 0; bus.s_data_i = 0;

    fork
      compare_loop();
      begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rd(BASE + 32'h8, d);
    check("status_after_reset", d, 32'h0000_0005);

    for (int i = 0; i < 16; i++) wr(BASE, 32'h100 + i);
    rd(BASE + 32'h8, d);
    check("status_in_full", d, 32'h0000_1006);
    wr(BASE, 32'h1FF);
    rd(BASE + 32'h8, d);
    check("status_in_ovf", d, 32'h0000_1016);
    bus.m_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("drain_order", bus.m_data_o, 32'h100 + k);
    end
    @(posedge clk); #1;
    bus.m_ready_i = 1'b0;

    n = 0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 32'h200;
    repeat (20) begin
      @(negedge clk);
      take = bus.s_ready_o;
      @(posedge clk); #1;
      if (take) begin
        n++;
        bus.s_data_i = 32'h200 + n;
      end
    end
    bus.s_valid_i = 1'b0;
    check("out_accepted", n, 16);
    check("s_ready_full", 32'(bus.s_ready_o), 32'd0);
    rd(BASE + 32'h8, d);
    check("status_out_full", d, 32'h0010_0019);
    for (int k = 0; k < 16; k++) begin
      rd(BASE + 32'h4, d);
      check("out_order", d, 32'h200 + k);
    end
    rd(BASE + 32'h4, d);
    check("underflow_data", d, 32'h0);
    rd(BASE + 32'h8, d);
    check("status_unf", d, 32'h0000_0035);
    wr(BASE + 32'hC, 32'h4);
    rd(BASE + 32'h8, d);
    check("status_cleared", d, 32'h0000_0005);

    bus.m_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr(BASE, 32'h300 + i);
      if (i % 8 == 7) begin
        rd(BASE + 32'h8, d);
        check("stream_through_status", d, 32'h0000_0005);
      end
    end
    bus.m_ready_i = 1'b0;

    wr(BASE, 32'hA);
    wr(BASE, 32'hB);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE + 32'hC; bus.wbs_dat_i = 32'h3;
    bus.s_data_i  = 32'h66;
    @(posedge clk); #1;
    bus.s_valid_i = 1'b0;
    @(negedge clk);
    check("flush_ack", 32'(bus.wbs_ack_o), 32'd1);
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    rd(BASE + 32'h8, d);
    check("status_after_flush", d, 32'h0000_0005);

    wb_xfer(1'b0, BASE + 32'h10, 32'h0, d, a);
    check("out_of_window_ack", 32'(a), 32'd0);

    wr(BASE, 32'h77);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h8;
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("ack_in_reset", 32'(bus.wbs_ack_o), 32'd0);
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    rst_n = 1'b1;
    rd(BASE + 32'h8, d);
    check("status_after_midreset", d, 32'h0000_0005);

    busy = 1'b0;
    age  = 0;
    for (int it = 0; it < 2000; it++) begin
      bus.m_ready_i = 1'($urandom_range(0, 1));
      bus.s_valid_i = ($urandom_range(0, 2) == 0);
      bus.s_data_i  = $urandom;
      if (busy) begin
        if (bus.wbs_ack_o || age >= 2) begin
          bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
          busy = 1'b0;
        end else begin
          age++;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 15);
        busy = 1'b1;
        age  = 0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_dat_i = $urandom;
        if (r < 5) begin
          bus.wbs_we_i = 1'b1; bus.wbs_adr_i = BASE;
        end else if (r < 9) begin
          bus.wbs_we_i = 1'b0; bus.wbs_adr_i = BASE + 32'h4;
        end else if (r < 11) begin
          bus.wbs_we_i = 1'b0; bus.wbs_adr_i = BASE + 32'h8;
        end else if (r == 11) begin
          bus.wbs_we_i = 1'b1; bus.wbs_adr_i = BASE + 32'hC;
          bus.wbs_dat_i = $urandom_range(0, 7);
        end else if (r == 12) begin
          bus.wbs_we_i = 1'b0; bus.wbs_adr_i = BASE + 32'h10;
        end else if (r == 13) begin
          bus.wbs_we_i = 1'b1; bus.wbs_adr_i = BASE - 32'h4;
        end else if (r == 14) begin
          bus.wbs_we_i = 1'b1; bus.wbs_adr_i = BASE + 32'h4 + 32'($urandom_range(0, 1)) * 32'h4;
        end else begin
          bus.wbs_we_i = 1'b0; bus.wbs_adr_i = ($urandom_range(0, 1) == 1) ? BASE : BASE + 32'hC;
        end
      end
      @(posedge clk); #1;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.s_valid_i = 1'b0; bus.m_ready_i = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wishbone_nn_stream_fifo.md
WISHBONE_NN_STREAM_FIFO -- requirements
Module: wishbone_nn_stream_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h3000_0000, meaning byte base of a 16-byte register window.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning FIFO word width; legal range 1..32.
REQ-003 SHALL have parameter DEPTH, default 16, meaning entries per FIFO; power of two, 2..128.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port wb_clk_i, input, 1, meaning the single clock; all flops on its rising edge.
REQ-006 SHALL have port wb_rst_ni, input, 1, meaning the asynchronous active-low reset.
REQ-007 SHALL have Wishbone slave ports wbs_stb_i/wbs_cyc_i/wbs_we_i (in, 1), wbs_sel_i (in, 4, ignored), wbs_adr_i/wbs_dat_i (in, 32), wbs_ack_o (out, 1) and wbs_dat_o (out, 32).
REQ-008 SHALL have stream master ports m_valid_o (out, 1), m_data_o (out, DATA_WIDTH) and m_ready_i (in, 1), all fed from the input FIFO to the NN core.
REQ-009 SHALL have stream slave ports s_valid_i (in, 1), s_data_i (in, DATA_WIDTH) and s_ready_o (out, 1), all fed from the NN core into the output FIFO.

Function
REQ-010 SHALL decode the register map as: BASE+0x0 DATA_IN (write pushes the input FIFO, read returns 0); BASE+0x4 DATA_OUT (read pops the output FIFO, write ignored); BASE+0x8 STATUS (read-only); BASE+0xC CTRL (write-only, read returns 0).
REQ-011 SHALL complete a request when stb&cyc&!ack_q is sampled at edge N on an address inside the window: wbs_ack_o high for exactly the one cycle after edge N; the push, pop, CTRL action and wbs_dat_o capture all occur at edge N.
REQ-012 SHALL never assert ack for addresses outside the window; wbs_dat_o SHALL be 0 whenever wbs_ack_o is low.
REQ-013 SHALL lay out STATUS as: [0] in_empty, [1] in_full, [2] out_empty, [3] out_full, [4] in_ovf, [5] out_unf, [15:8] in_count, [23:16] out_count, other bits 0; counts are zero-extended and range 0..DEPTH.
REQ-014 SHALL give CTRL these write-1 actions: bit0 flushes the input FIFO, bit1 flushes the output FIFO, bit2 clears in_ovf and out_unf; bits act independently.
REQ-015 SHALL implement the input FIFO as first-word-fall-through: m_valid_o = !in_empty, m_data_o = head word (0 when empty), and a pop occurs at any edge with m_valid_o&m_ready_i.
REQ-016 SHALL drive s_ready_o = !out_full and push the output FIFO at any edge with s_valid_i&s_ready_o.
REQ-017 SHALL treat a DATA_IN write when in_full as follows: data dropped, ack given, in_ovf set sticky; this holds even if a stream pop occurs the same edge.
REQ-018 SHALL treat a DATA_OUT read when out_empty as follows: returns 0, ack given, out_unf set sticky.
REQ-019 SHALL, on a simultaneous push and pop to the same non-full, non-empty FIFO, perform both with the count unchanged.
REQ-020 SHALL truncate written data to DATA_WIDTH LSBs and zero-extend read data to 32 bits.
REQ-021 SHALL make a flush zero that FIFO's pointers and count at edge N, overriding any same-edge push or pop on it.
REQ-022 SHALL make a CTRL error-clear at the same edge as a new error event leave the flag set.
REQ-023 SHALL wrap pointers modulo DEPTH without loss of data.

Reset
REQ-024 SHALL, while wb_rst_ni is low, hold wbs_ack_o=0, wbs_dat_o=0, m_valid_o=0, m_data_o=0, s_ready_o=0, both FIFOs empty and both flags clear.
REQ-025 SHALL, after release, drive s_ready_o=1 from the first cycle.
REQ-026 SHALL, on a reset mid-transaction, abort the transaction with no ack; FIFO memory contents are not reset.

Verification
REQ-027 SHALL cover: reset, then read STATUS -> 0x0000_0005.
REQ-028 SHALL cover: 16 DATA_IN writes of 0x100+i with m_ready_i=0 -> STATUS in_full=1, in_count=16; a 17th write -> acked and in_ovf=1; then m_ready_i=1 -> m_data_o yields 0x100..0x10F in order over 16 cycles.
REQ-029 SHALL cover: s_valid_i held for 17 words -> s_ready_o low after 16 words; 16 DATA_OUT reads return words in order; a 17th read -> 0 and out_unf=1; CTRL write 0x4 -> both flags clear.
REQ-030 SHALL cover: continuous DATA_IN writes with m_ready_i=1 across 40 words -> no loss across pointer wrap and in_count never exceeds 1.
REQ-031 SHALL cover: CTRL write 0x3 on the same edge as a stream push -> both FIFOs empty afterwards.
REQ-032 SHALL cover: a read at BASE+0x10 -> wbs_ack_o stays 0; wb_rst_ni pulsed low mid-transaction -> ack suppressed and STATUS=0x0000_0005.
